// File: rtl/tensor_core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tensor_core_pkg : shared types for the tensor core sequencer             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package tensor_core_pkg;

    localparam int BUS_WIDTH = 7;

    typedef logic signed [BUS_WIDTH:0] elem_t;
    typedef elem_t [3:0][3:0]          matrix_t;

    typedef enum logic [1:0] {
        OP_MATMUL = 2'b00,
        OP_ADD    = 2'b01,
        OP_RELU   = 2'b10
    } op_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD_A    = 4'd1,
        ST_LOAD_B    = 4'd2,
        ST_WRITE_REG = 4'd3,
        ST_SYNC      = 4'd4,
        ST_START     = 4'd5,
        ST_GUARD     = 4'd6,
        ST_WAIT_DONE = 4'd7,
        ST_DRAIN     = 4'd8
    } seq_state_t;

    // Both 2'b10 and 2'b11 select relu, which needs only one operand.
    function automatic logic is_relu(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_byte_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_byte_loader : 16-entry row-major byte deserializer with index     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module matrix_byte_loader #(
    parameter int BUS_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic                         i_write,
    input  logic                         i_advance,
    input  logic [BUS_WIDTH:0]           i_data,
    output logic [3:0][3:0][BUS_WIDTH:0] o_matrix,
    output logic [3:0]                   o_index
);

    logic [3:0][3:0][BUS_WIDTH:0] r_matrix;
    logic [3:0]                   r_index;

    // i_advance steps the index without writing, so the counter can also walk a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_matrix <= '0;
            r_index  <= '0;
        end else begin
            if (i_write) begin
                r_matrix[r_index[3:2]][r_index[1:0]] <= i_data;
            end
            if (i_clear) begin
                r_index <= '0;
            end else if (i_write || i_advance) begin
                r_index <= r_index + 4'd1;
            end
        end
    end

    assign o_matrix = r_matrix;
    assign o_index  = r_index;

endmodule
`default_nettype wire

// File: rtl/tensor_core_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tensor_core_sequencer : loads operands, runs the tensor core, drains     |
// | the result matrix. Revision: 1.0                                         |
// +--------------------------------------------------------------------------+
module tensor_core_sequencer #(
    parameter int BUS_WIDTH      = 7,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic                         cmd_valid_in,
    output logic                         cmd_ready_out,
    input  logic [1:0]                   cmd_op_in,
    input  logic                         data_valid_in,
    output logic                         data_ready_out,
    input  logic [BUS_WIDTH:0]           data_in,
    output logic                         result_valid_out,
    input  logic                         result_ready_in,
    output logic [BUS_WIDTH:0]           result_data_out,
    output logic                         result_last_out,
    output logic [3:0][3:0][BUS_WIDTH:0] core_input1_out,
    output logic [3:0][3:0][BUS_WIDTH:0] core_input2_out,
    output logic                         core_write_enable_out,
    output logic                         core_start_out,
    output logic [1:0]                   core_op_out,
    input  logic [3:0][3:0][BUS_WIDTH:0] core_output_in,
    input  logic                         core_done_in,
    output logic                         busy_out,
    output logic                         timeout_error_out
);
    import tensor_core_pkg::*;

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    seq_state_t                   r_state;
    seq_state_t                   w_state_next;
    logic [1:0]                   r_op;
    logic                         r_timeout;
    logic [c_CNT_W-1:0]           r_tmo_cnt;
    logic [3:0][3:0][BUS_WIDTH:0] r_result;
    logic [3:0]                   w_idx_a;
    logic [3:0]                   w_idx_b;
    logic                         w_cmd_hs;
    logic                         w_load_a_hs;
    logic                         w_load_b_hs;
    logic                         w_result_hs;
    logic                         w_capture;
    logic                         w_timeout_hit;

    // Ready is masked by reset so every output reads 0 while reset is held.
    assign cmd_ready_out         = reset_n_in && (r_state == ST_IDLE);
    assign data_ready_out        = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    assign result_valid_out      = (r_state == ST_DRAIN);
    assign result_last_out       = result_valid_out && (w_idx_a == 4'd15);
    assign result_data_out       = result_valid_out ? r_result[w_idx_a[3:2]][w_idx_a[1:0]] : '0;
    assign core_write_enable_out = (r_state == ST_WRITE_REG);
    assign core_start_out        = (r_state == ST_START);
    assign core_op_out           = core_start_out ? r_op : 2'b00;
    assign busy_out              = (r_state != ST_IDLE);
    assign timeout_error_out     = r_timeout;

    assign w_cmd_hs      = cmd_valid_in && cmd_ready_out;
    assign w_load_a_hs   = data_valid_in && (r_state == ST_LOAD_A);
    assign w_load_b_hs   = data_valid_in && (r_state == ST_LOAD_B);
    assign w_result_hs   = result_valid_out && result_ready_in;
    assign w_capture     = (r_state == ST_WAIT_DONE) && core_done_in;
    assign w_timeout_hit = (r_state == ST_WAIT_DONE) && !core_done_in && (r_tmo_cnt == '0);

    // The A loader's index doubles as the drain pointer.
    matrix_byte_loader #(.BUS_WIDTH(BUS_WIDTH)) u_load_a (
        .clk       (clock_in),
        .rst_n     (reset_n_in),
        .i_clear   (w_cmd_hs),
        .i_write   (w_load_a_hs),
        .i_advance (w_result_hs),
        .i_data    (data_in),
        .o_matrix  (core_input1_out),
        .o_index   (w_idx_a)
    );

    matrix_byte_loader #(.BUS_WIDTH(BUS_WIDTH)) u_load_b (
        .clk       (clock_in),
        .rst_n     (reset_n_in),
        .i_clear   (w_cmd_hs),
        .i_write   (w_load_b_hs),
        .i_advance (1'b0),
        .i_data    (data_in),
        .o_matrix  (core_input2_out),
        .o_index   (w_idx_b)
    );

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_cmd_hs) w_state_next = ST_LOAD_A;
            ST_LOAD_A:    if (w_load_a_hs && (w_idx_a == 4'd15))
                              w_state_next = is_relu(r_op) ? ST_WRITE_REG : ST_LOAD_B;
            ST_LOAD_B:    if (w_load_b_hs && (w_idx_b == 4'd15)) w_state_next = ST_WRITE_REG;
            ST_WRITE_REG: w_state_next = ST_SYNC;
            ST_SYNC:      if (core_done_in) w_state_next = ST_START;
            ST_START:     w_state_next = ST_GUARD;
            ST_GUARD:     w_state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (w_capture)          w_state_next = ST_DRAIN;
                else if (w_timeout_hit) w_state_next = ST_IDLE;
            end
            ST_DRAIN:     if (w_result_hs && (w_idx_a == 4'd15)) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    // Timeout counter counts down from TIMEOUT_CYCLES-1 so WAIT_DONE lasts TIMEOUT_CYCLES cycles.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_op      <= 2'b00;
            r_timeout <= 1'b0;
            r_tmo_cnt <= '0;
            r_result  <= '0;
        end else begin
            if (w_cmd_hs) begin
                r_op      <= cmd_op_in;
                r_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            if (r_state == ST_GUARD) begin
                r_tmo_cnt <= c_CNT_W'(TIMEOUT_CYCLES - 1);
            end else if ((r_state == ST_WAIT_DONE) && (r_tmo_cnt != '0)) begin
                r_tmo_cnt <= r_tmo_cnt - 1'b1;
            end
            if (w_capture) begin
                r_result <= core_output_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tensor_core_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tensor_core_sequencer : directed bench with a behavioural core model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tensor_core_sequencer;

    localparam int TMO      = 64;
    localparam int LAT      = 3;
    localparam int M_NORMAL = 0;
    localparam int M_STALE  = 1;
    localparam int M_NEVER  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic              cmd_valid_in = 1'b0;
    logic              cmd_ready_out;
    logic [1:0]        cmd_op_in = 2'b00;
    logic              data_valid_in = 1'b0;
    logic              data_ready_out;
    logic [7:0]        data_in = 8'h00;
    logic              result_valid_out;
    logic              result_ready_in = 1'b0;
    logic [7:0]        result_data_out;
    logic              result_last_out;
    logic [15:0][7:0]  core_in1;
    logic [15:0][7:0]  core_in2;
    logic              core_write_enable_out;
    logic              core_start_out;
    logic [1:0]        core_op_out;
    logic [15:0][7:0]  core_out;
    logic              core_done;
    logic              busy_out;
    logic              timeout_error_out;

    tensor_core_sequencer #(.BUS_WIDTH(7), .TIMEOUT_CYCLES(TMO)) dut (
        .clock_in              (clk),
        .reset_n_in            (rst_n),
        .cmd_valid_in          (cmd_valid_in),
        .cmd_ready_out         (cmd_ready_out),
        .cmd_op_in             (cmd_op_in),
        .data_valid_in         (data_valid_in),
        .data_ready_out        (data_ready_out),
        .data_in               (data_in),
        .result_valid_out      (result_valid_out),
        .result_ready_in       (result_ready_in),
        .result_data_out       (result_data_out),
        .result_last_out       (result_last_out),
        .core_input1_out       (core_in1),
        .core_input2_out       (core_in2),
        .core_write_enable_out (core_write_enable_out),
        .core_start_out        (core_start_out),
        .core_op_out           (core_op_out),
        .core_output_in        (core_out),
        .core_done_in          (core_done),
        .busy_out              (busy_out),
        .timeout_error_out     (timeout_error_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = M_NORMAL;

    function automatic logic [15:0][7:0] core_calc(input logic [15:0][7:0] a, input logic [15:0][7:0] b,
                                                   input logic [1:0] op);
        logic [15:0][7:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (op == 2'b00) begin
                    s = 0;
                    for (int k = 0; k < 4; k++) s += $signed(a[i*4+k]) * $signed(b[k*4+j]);
                end else if (op == 2'b01) begin
                    s = $signed(a[i*4+j]) + $signed(b[i*4+j]);
                end else begin
                    s = ($signed(a[i*4+j]) < 0) ? 0 : int'($signed(a[i*4+j]));
                end
                r[i*4+j] = s[7:0];
            end
        end
        return r;
    endfunction

    // Behavioural tensor core: done idles high, drops on start, rises LAT cycles later.
    logic [15:0][7:0] cm_a, cm_b;
    logic [1:0]       cm_op;
    logic             cm_run;
    int               cm_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done <= 1'b1;
            cm_run    <= 1'b0;
            cm_cnt    <= 0;
            core_out  <= '0;
            cm_a      <= '0;
            cm_b      <= '0;
            cm_op     <= 2'b00;
        end else begin
            if (core_write_enable_out) begin
                cm_a <= core_in1;
                cm_b <= core_in2;
            end
            if (core_start_out) begin
                cm_op     <= core_op_out;
                cm_run    <= 1'b1;
                cm_cnt    <= LAT;
                core_done <= (mode == M_STALE);
                if (mode == M_STALE) core_out <= {16{8'h55}};
            end else if (cm_run) begin
                if (cm_cnt != 0) begin
                    cm_cnt    <= cm_cnt - 1;
                    core_done <= 1'b0;
                end else if (mode != M_NEVER) begin
                    core_done <= 1'b1;
                    core_out  <= core_calc(cm_a, cm_b, cm_op);
                    cm_run    <= 1'b0;
                end
            end
        end
    end

    logic       m_clr = 1'b0;
    int         m_we, m_st, m_dhs, m_nres, m_last_cnt, m_last_idx, m_unstable;
    logic [1:0] m_op;
    logic       m_anyvalid, m_prev_stall;
    logic [7:0] m_prev_data;
    logic [7:0] m_resq[$];

    always @(negedge clk) begin
        if (m_clr) begin
            m_we <= 0; m_st <= 0; m_dhs <= 0; m_nres <= 0;
            m_last_cnt <= 0; m_last_idx <= -1; m_unstable <= 0;
            m_op <= 2'b11; m_anyvalid <= 1'b0;
            m_resq.delete();
        end else begin
            if (core_write_enable_out) m_we <= m_we + 1;
            if (core_start_out) begin
                m_st <= m_st + 1;
                m_op <= core_op_out;
            end
            if (data_valid_in && data_ready_out) m_dhs <= m_dhs + 1;
            if (result_valid_out) m_anyvalid <= 1'b1;
            if (result_valid_out && result_ready_in) begin
                m_resq.push_back(result_data_out);
                m_nres <= m_nres + 1;
                if (result_last_out) begin
                    m_last_cnt <= m_last_cnt + 1;
                    m_last_idx <= m_nres;
                end
            end
            if (m_prev_stall && result_valid_out && (result_data_out !== m_prev_data))
                m_unstable <= m_unstable + 1;
        end
        m_prev_stall <= result_valid_out && !result_ready_in;
        m_prev_data  <= result_data_out;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op);
        logic acc = 1'b0;
        int   g   = 0;
        cmd_valid_in = 1'b1;
        cmd_op_in    = op;
        while (!acc && g < 200) begin
            @(negedge clk); acc = cmd_ready_out;
            @(posedge clk); #1; g++;
        end
        cmd_valid_in = 1'b0;
        if (!acc) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic feed(input logic [15:0][7:0] a, input logic [15:0][7:0] b, input int nbytes, input int gap);
        int   k = 0;
        int   g = 0;
        logic hs;
        while (k < nbytes && g < 3000) begin
            data_valid_in = ($urandom_range(99) >= gap);
            data_in       = (k < 16) ? a[k] : b[k-16];
            @(negedge clk); hs = data_valid_in && data_ready_out;
            @(posedge clk); #1;
            if (hs) k++;
            g++;
        end
        data_valid_in = 1'b0;
        if (k < nbytes) chk("feed_timeout", k, nbytes);
    endtask

    task automatic consume(input int bp);
        logic fin = 1'b0;
        int   g   = 0;
        while (!fin && g < 3000) begin
            result_ready_in = ($urandom_range(99) >= bp);
            @(negedge clk);
            if (result_valid_out && result_ready_in && result_last_out) fin = 1'b1;
            @(posedge clk); #1; g++;
        end
        result_ready_in = 1'b0;
        if (!fin) chk("drain_timeout", 0, 1);
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [15:0][7:0] a;
        logic [15:0][7:0] b;
        logic [15:0][7:0] exp_b;
        logic [15:0][7:0] exp;
        int               gap;
        int               bp;
    } vec_t;

    vec_t vt[5];

    task automatic run_vec(input vec_t v, input int id);
        logic [15:0][7:0] got = '0;
        int nb;
        nb = v.op[1] ? 16 : 32;
        m_clr = 1'b1;
        @(posedge clk); #1;
        m_clr = 1'b0;
        send_cmd(v.op);
        chk($sformatf("v%0d_err_clear", id), timeout_error_out, 0);
        fork
            begin
                feed(v.a, v.b, nb, v.gap);
                chk($sformatf("v%0d_ready_drop", id), data_ready_out, 0);
            end
            consume(v.bp);
        join
        for (int i = 0; i < 16 && i < m_resq.size(); i++) got[i] = m_resq[i];
        chk($sformatf("v%0d_result", id), got, v.exp);
        chk($sformatf("v%0d_last", id), {m_nres[7:0], m_last_cnt[7:0], m_last_idx[7:0]}, {8'd16, 8'd1, 8'd15});
        chk($sformatf("v%0d_we_pulse", id), m_we, 1);
        chk($sformatf("v%0d_start_pulse", id), m_st, 1);
        chk($sformatf("v%0d_start_op", id), m_op, v.op);
        chk($sformatf("v%0d_load_cnt", id), m_dhs, nb);
        chk($sformatf("v%0d_stall_stable", id), m_unstable, 0);
        chk($sformatf("v%0d_mat_a", id), core_in1, v.a);
        chk($sformatf("v%0d_mat_b", id), core_in2, v.exp_b);
        chk($sformatf("v%0d_idle", id), {busy_out, cmd_ready_out}, 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int started, n, g, k;

        for (int i = 0; i < 16; i++) begin
            vt[0].op = 2'b00; vt[0].a[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
            vt[0].b[i] = 8'(i); vt[0].exp_b[i] = 8'(i); vt[0].exp[i] = 8'(i);
            vt[0].gap = 0; vt[0].bp = 0;

            vt[1].op = 2'b01; vt[1].a[i] = 8'd3; vt[1].b[i] = 8'hFB;
            vt[1].exp_b[i] = 8'hFB; vt[1].exp[i] = 8'hFE; vt[1].gap = 0; vt[1].bp = 0;

            vt[2].op = 2'b10; vt[2].b[i] = 8'h11; vt[2].exp_b[i] = 8'hFB;
            case (i % 4)
                0: begin vt[2].a[i] = 8'hFF; vt[2].exp[i] = 8'd0; end
                1: begin vt[2].a[i] = 8'h02; vt[2].exp[i] = 8'd2; end
                2: begin vt[2].a[i] = 8'hFD; vt[2].exp[i] = 8'd0; end
                default: begin vt[2].a[i] = 8'h04; vt[2].exp[i] = 8'd4; end
            endcase
            vt[2].gap = 0; vt[2].bp = 0;

            vt[3].op = 2'b00; vt[3].a[i] = 8'd1; vt[3].b[i] = 8'(i); vt[3].exp_b[i] = 8'(i);
            vt[3].exp[i] = 8'(24 + 4 * (i % 4)); vt[3].gap = 40; vt[3].bp = 40;

            vt[4].op = 2'b01; vt[4].a[i] = 8'h64; vt[4].b[i] = 8'(i); vt[4].exp_b[i] = 8'(i);
            vt[4].exp[i] = 8'(100 + i); vt[4].gap = 30; vt[4].bp = 50;
        end

        #1 rst_n = 1'b0;
        #20;
        chk("rst_strobes", {cmd_ready_out, data_ready_out, result_valid_out, result_last_out,
                            core_write_enable_out, core_start_out, busy_out, timeout_error_out}, 8'h00);
        chk("rst_matrices", {core_in1, core_in2}, '0);
        chk("rst_result", {core_op_out, result_data_out}, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", {cmd_ready_out, busy_out}, 2'b10);

        for (int v = 0; v < 5; v++) run_vec(vt[v], v);

        // Done held high through GUARD over a garbage core output.
        mode = M_STALE;
        run_vec(vt[0], 10);
        mode = M_NORMAL;

        // Core never completes.
        mode = M_NEVER;
        m_clr = 1'b1; @(posedge clk); #1; m_clr = 1'b0;
        send_cmd(2'b10);
        feed(vt[2].a, vt[2].b, 16, 0);
        started = 0; n = 0; g = 0;
        while (!(started != 0 && !busy_out) && g < 400) begin
            @(negedge clk);
            if (core_start_out) started = 1;
            else if (started != 0 && busy_out) n++;
            g++;
        end
        chk("tmo_cycles", n, TMO + 1);
        chk("tmo_error", timeout_error_out, 1);
        chk("tmo_idle", {busy_out, cmd_ready_out}, 2'b01);
        chk("tmo_no_result", m_anyvalid, 0);
        mode = M_NORMAL;
        @(posedge clk); #1;
        run_vec(vt[0], 20);
        chk("tmo_cleared", timeout_error_out, 0);

        // Reset in LOAD_B with index 7.
        send_cmd(2'b01);
        feed(vt[1].a, vt[1].b, 23, 0);
        chk("midb_state", {busy_out, data_ready_out}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("midb_rst_out", {busy_out, data_ready_out, core_write_enable_out, core_start_out, cmd_ready_out}, 5'b0);
        chk("midb_rst_mat", {core_in1, core_in2}, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_vec(vt[1], 30);

        // Reset in DRAIN after three results.
        send_cmd(2'b00);
        feed(vt[0].a, vt[0].b, 32, 0);
        k = 0; g = 0;
        while (k < 3 && g < 500) begin
            result_ready_in = 1'b1;
            @(negedge clk);
            if (result_valid_out && result_ready_in) k++;
            @(posedge clk); #1; g++;
        end
        result_ready_in = 1'b0;
        chk("midd_draining", {result_valid_out, result_data_out}, {1'b1, 8'd3});
        #2 rst_n = 1'b0;
        #1;
        chk("midd_rst_out", {result_valid_out, result_last_out, result_data_out, busy_out}, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_vec(vt[3], 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
